// File: rtl/ssd_scan_controller.sv
// Seven-segment scan controller: buffers the last two UART bytes and multiplexes
// four digits with a blanking window at the start of each digit period.
module ssd_scan_controller #(
    parameter int unsigned CLKS_PER_DIGIT = 208_333,
    parameter int unsigned BLANK_CYCLES   = 2_500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       clr,
    output logic [3:0] dig_sel,
    output logic [3:0] nibble,
    output logic       dash,
    output logic       frame_tick
);

    localparam int unsigned CW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
    localparam logic [CW-1:0] TC    = CW'(CLKS_PER_DIGIT - 1);
    localparam logic [CW-1:0] BLANK = CW'(BLANK_CYCLES);

    // idx is the scan state; it advances only at prescaler terminal count.
    typedef enum logic [1:0] {D0, D1, D2, D3} digit_t;

    digit_t        idx, idx_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          tc;

    logic [7:0] slot0, slot1;
    logic       v0, v1;

    logic [3:0] sel_next;
    logic [3:0] nibble_next;
    logic       dash_next;
    logic       frame_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= D0;
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
        end
    end

    always_comb begin
        tc       = (cnt == TC);
        cnt_next = tc ? '0 : cnt + 1'b1;
        idx_next = idx;
        if (tc) begin
            case (idx)
                D0:      idx_next = D1;
                D1:      idx_next = D2;
                D2:      idx_next = D3;
                default: idx_next = D0;
            endcase
        end
    end

    // A simultaneous clr and rx_valid leaves only the new byte valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot0 <= 8'h00;
            slot1 <= 8'h00;
            v0    <= 1'b0;
            v1    <= 1'b0;
        end else if (rx_valid) begin
            slot1 <= slot0;
            slot0 <= rx_data;
            v0    <= 1'b1;
            v1    <= clr ? 1'b0 : v0;
        end else if (clr) begin
            v0 <= 1'b0;
            v1 <= 1'b0;
        end
    end

    always_comb begin
        sel_next    = 4'b1111;
        nibble_next = 4'h0;
        dash_next   = 1'b1;
        case (idx)
            D0: begin
                sel_next    = 4'b1110;
                nibble_next = slot0[3:0];
                dash_next   = !v0;
            end
            D1: begin
                sel_next    = 4'b1101;
                nibble_next = slot0[7:4];
                dash_next   = !v0;
            end
            D2: begin
                sel_next    = 4'b1011;
                nibble_next = slot1[3:0];
                dash_next   = !v1;
            end
            default: begin
                sel_next    = 4'b0111;
                nibble_next = slot1[7:4];
                dash_next   = !v1;
            end
        endcase
        // Data still follows idx while blanked so it has settled before enable.
        if (cnt < BLANK) begin
            sel_next = 4'b1111;
        end
        frame_next = tc && (idx == D3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dig_sel    <= 4'b1111;
            nibble     <= 4'h0;
            dash       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            dig_sel    <= sel_next;
            nibble     <= nibble_next;
            dash       <= dash_next;
            frame_tick <= frame_next;
        end
    end

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller: one instance with blanking, one without,
// sharing stimulus; outputs checked every cycle against hand-set digit contents.
module tb_ssd_scan_controller;

    localparam int CPD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;

    logic [3:0] dig_sel, nibble, dig_sel_z, nibble_z;
    logic       dash, frame_tick, dash_z, frame_tick_z;

    int vectors = 0;
    int errors  = 0;
    int pos     = 0;

    logic [3:0] cur_nib[4];
    logic [3:0] pend_nib[4];
    logic       cur_dash[4];
    logic       pend_dash[4];
    logic [3:0] sel_tab[4];

    ssd_scan_controller #(.CLKS_PER_DIGIT(CPD), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .clr(clr),
        .dig_sel(dig_sel), .nibble(nibble), .dash(dash), .frame_tick(frame_tick)
    );

    ssd_scan_controller #(.CLKS_PER_DIGIT(CPD), .BLANK_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .clr(clr),
        .dig_sel(dig_sel_z), .nibble(nibble_z), .dash(dash_z), .frame_tick(frame_tick_z)
    );

    always #5 clk = ~clk;

    task automatic chk4(input string tag, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @pos %0d: got %h expected %h", tag, pos, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s @pos %0d: got %b expected %b", tag, pos, got, exp);
        end
    endtask

    // One clock; outputs reflect the scan/buffer state that held before the edge.
    task automatic tick();
        int c, i;
        logic [3:0] esel;
        @(posedge clk);
        #1;
        c    = pos % CPD;
        i    = (pos / CPD) % 4;
        esel = (c < 2) ? 4'b1111 : sel_tab[i];
        chk4("dig_sel", dig_sel, esel);
        chk4("dig_sel_noblank", dig_sel_z, sel_tab[i]);
        chk1("dash", dash, cur_dash[i]);
        chk1("dash_noblank", dash_z, cur_dash[i]);
        if (!cur_dash[i]) begin
            chk4("nibble", nibble, cur_nib[i]);
            chk4("nibble_noblank", nibble_z, cur_nib[i]);
        end
        chk1("frame_tick", frame_tick, (pos % 32) == 31);
        chk1("frame_tick_noblank", frame_tick_z, (pos % 32) == 31);
        pos++;
        cur_nib  = pend_nib;
        cur_dash = pend_dash;
    endtask

    task automatic reset_tick();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk4("rst_dig_sel", dig_sel, 4'b1111);
        chk4("rst_nibble", nibble, 4'h0);
        chk1("rst_dash", dash, 1'b1);
        chk1("rst_frame_tick", frame_tick, 1'b0);
        chk4("rst_dig_sel_noblank", dig_sel_z, 4'b1111);
        chk1("rst_dash_noblank", dash_z, 1'b1);
        rst       = 1'b0;
        pos       = 0;
        pend_nib  = '{4'h0, 4'h0, 4'h0, 4'h0};
        pend_dash = '{1'b1, 1'b1, 1'b1, 1'b1};
        cur_nib   = pend_nib;
        cur_dash  = pend_dash;
    endtask

    initial begin
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset, then two empty frames: blanking pattern and frame_tick spacing.
        reset_tick();
        for (int k = 0; k < 64; k++) tick();

        // Single byte A5.
        rx_valid = 1'b1; rx_data = 8'hA5;
        pend_nib  = '{4'h5, 4'hA, 4'h0, 4'h0};
        pend_dash = '{1'b0, 1'b0, 1'b1, 1'b1};
        tick();
        rx_valid = 1'b0;
        for (int k = 0; k < 32; k++) tick();

        // Back-to-back 3C, 7E.
        rx_valid = 1'b1; rx_data = 8'h3C;
        pend_nib  = '{4'hC, 4'h3, 4'h5, 4'hA};
        pend_dash = '{1'b0, 1'b0, 1'b0, 1'b0};
        tick();
        rx_data = 8'h7E;
        pend_nib  = '{4'hE, 4'h7, 4'hC, 4'h3};
        tick();
        rx_valid = 1'b0;
        for (int k = 0; k < 32; k++) tick();

        // clr together with a new byte 12: only slot0 remains valid.
        clr = 1'b1; rx_valid = 1'b1; rx_data = 8'h12;
        pend_nib  = '{4'h2, 4'h1, 4'hE, 4'h7};
        pend_dash = '{1'b0, 1'b0, 1'b1, 1'b1};
        tick();
        clr = 1'b0; rx_valid = 1'b0;
        for (int k = 0; k < 32; k++) tick();

        // clr alone blanks every digit to dash.
        clr = 1'b1;
        pend_dash = '{1'b1, 1'b1, 1'b1, 1'b1};
        tick();
        clr = 1'b0;
        for (int k = 0; k < 32; k++) tick();

        // rx_valid held two cycles with 21: two shifts.
        rx_valid = 1'b1; rx_data = 8'h21;
        pend_nib  = '{4'h1, 4'h2, 4'h2, 4'h1};
        pend_dash = '{1'b0, 1'b0, 1'b1, 1'b1};
        tick();
        pend_nib  = '{4'h1, 4'h2, 4'h1, 4'h2};
        pend_dash = '{1'b0, 1'b0, 1'b0, 1'b0};
        tick();
        rx_valid = 1'b0;
        for (int k = 0; k < 32; k++) tick();

        // Reset in the middle of digit 2 with both slots valid.
        while ((pos % 32) != 19) tick();
        reset_tick();
        for (int k = 0; k < 40; k++) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ssd_scan_controller.md
# ssd_scan_controller

Display scan controller for the UART SSD path. It captures received UART bytes into a two-byte display buffer and time-multiplexes the four seven-segment digits at a prescaled rate. Digit-enable blanking between digits prevents ghosting. It sits between the UART receiver (`rx_data`/`rx_valid`) and the combinational segment decoder (`nibble`/`dash` → segments), and drives the digit selects directly.

## Interface
- `CLKS_PER_DIGIT`, 208_333: clock cycles each digit is scanned (≈60 Hz frame for 4 digits at 50 MHz); legal range ≥ 2.
- `BLANK_CYCLES`, 2_500: cycles at the start of each digit period with all digits off; legal range 0 … `CLKS_PER_DIGIT`-1.

- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset, synchronous, active-high; one clock; all state cleared on the rising clk edge where rst=1.
- `rx_data`  in  8  received byte; sampled only when `rx_valid`=1.
- `rx_valid`  in  1  single-cycle strobe from the UART receiver.
- `clr`  in  1  synchronous clear of the display buffer (all digits show dash).
- `dig_sel`  out  4  digit enables, active-low, one-hot-low or 4'b1111 when blanking.
- `nibble`  out  4  hex value for the currently enabled digit.
- `dash`  out  1  1 = decoder shows dash instead of `nibble`.
- `frame_tick`  out  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation
- Buffer: `slot0[7:0]`, `slot1[7:0]`, valid flags `v0` and `v1`.
  - On `rx_valid`: `slot1` ← `slot0`, `v1` ← `v0`, `slot0` ← `rx_data`, `v0` ← 1.
  - On `clr` alone: `v0` ← 0, `v1` ← 0. Slot data is unchanged and don't-care.
  - `clr` and `rx_valid` in the same cycle: buffer cleared, then the new byte is loaded. Result: `slot0` = `rx_data`, `v0` = 1, `v1` = 0.
- Prescaler: counter `cnt` counts 0 … `CLKS_PER_DIGIT`-1.
  - At terminal count, `cnt` → 0 and digit index `idx` advances 0→1→2→3→0 (2-bit wrap).
  - `frame_tick` asserts on the cycle when `idx` goes from 3 to 0.
- Digit mapping, selected from `idx`:
  - idx0: `dig_sel` = 4'b1110, `nibble` = `slot0[3:0]`, `dash` = !`v0`.
  - idx1: `dig_sel` = 4'b1101, `nibble` = `slot0[7:4]`, `dash` = !`v0`.
  - idx2: `dig_sel` = 4'b1011, `nibble` = `slot1[3:0]`, `dash` = !`v1`.
  - idx3: `dig_sel` = 4'b0111, `nibble` = `slot1[7:4]`, `dash` = !`v1`.
- Blanking: while `cnt` < `BLANK_CYCLES`, `dig_sel` = 4'b1111. `nibble` and `dash` still follow `idx`, so the data settles before the digit is enabled. With `BLANK_CYCLES` = 0 there is no blanking.
- Data arriving mid-digit updates `nibble`/`dash` without waiting for the next digit period.
- State machine: there is no explicit FSM. `idx` is the scan state with states D0, D1, D2, D3. The only transition is Dn→D(n+1 mod 4) at `cnt` terminal count, and `rst` forces D0.

## Timing
- All outputs are registered. Each output at edge t+1 is a function of `cnt`, `idx` and buffer state after edge t, i.e. one cycle of latency from a state change to the pin.
- `rx_valid` at edge t → buffer updated at t → `nibble`/`dash` reflect the new byte at t+1.
- Reset values:
  - `dig_sel` = 4'b1111, `nibble` = 4'h0, `dash` = 1, `frame_tick` = 0.
  - `cnt` = 0, `idx` = 0, `v0` = `v1` = 0, `slot0` = `slot1` = 8'h00.
- Reset mid-scan or mid-update: state is discarded immediately. The first cycle after reset restarts at D0 with `cnt` = 0 and both slots invalid.
- `rx_valid` held high for N cycles is treated as N bytes, one shift per cycle.
- Digit period is exactly `CLKS_PER_DIGIT` cycles. Frame period is exactly 4·`CLKS_PER_DIGIT` cycles, and `frame_tick` spacing equals the frame period.
- Counter widths are $clog2(`CLKS_PER_DIGIT`). There is no overflow path; terminal-count compare is equality.

## Test plan
Bench parameters: `CLKS_PER_DIGIT` = 8, `BLANK_CYCLES` = 2.
- Reset → `dig_sel` = 1111, `dash` = 1 on every digit for a full frame. `dig_sel` sequence is 1111,1111, then 1110 ×6, then 1111,1111, then 1101 ×6, and so on. `frame_tick` spacing is 32 cycles.
- `rx_valid` with 8'hA5 → digit0 `nibble` = 5 with `dash` = 0, digit1 `nibble` = A with `dash` = 0, digits 2 and 3 `dash` = 1. Change is visible one cycle after the strobe.
- 8'h3C then 8'h7E on consecutive cycles → digits 0–3 show E, 7, C, 3, all with `dash` = 0.
- `clr` and `rx_valid` (8'h12) in the same cycle after two prior bytes → digits 0 and 1 show 2 and 1, digits 2 and 3 `dash` = 1.
- `rst` asserted for 1 cycle mid-digit-2 with both slots valid → next cycle `dig_sel` = 1111, `dash` = 1, and the scan restarts at digit 0 with a full 8-cycle period.
- `BLANK_CYCLES` = 0 → `dig_sel` is never 1111 after the first post-reset cycle, and each digit is enabled for exactly 8 cycles.
